// File: rtl/core_pkg.sv
// Shared definitions for the accumulator core: opcodes, FSM states, register file geometry.
// The mailbox halt feature is enabled by defining CORE_MAILBOX_HALT_EN.
package core_pkg;

   localparam int NREGS       = 32;
   localparam int IMM_W       = 5;
   localparam int OP_W        = 3;
   localparam int MAILBOX_REG = 31;

   localparam logic [OP_W-1:0] OP_LDI  = 3'd0;
   localparam logic [OP_W-1:0] OP_LDA  = 3'd1;
   localparam logic [OP_W-1:0] OP_STA  = 3'd2;
   localparam logic [OP_W-1:0] OP_ADD  = 3'd3;
   localparam logic [OP_W-1:0] OP_SUB  = 3'd4;
   localparam logic [OP_W-1:0] OP_LW   = 3'd5;
   localparam logic [OP_W-1:0] OP_SW   = 3'd6;
   localparam logic [OP_W-1:0] OP_BEQZ = 3'd7;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_MEM   = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   function automatic logic is_mailbox(input logic [IMM_W-1:0] idx);
      return idx == IMM_W'(MAILBOX_REG);
   endfunction

endpackage

// File: rtl/core_regfile.sv
// 32-entry register file: one synchronous write port, combinational execute and debug reads.
// All entries clear on asynchronous reset; R0 is an ordinary register.
module core_regfile
   import core_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IMM_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IMM_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata,
   input  logic [IMM_W-1:0]  dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   logic [NREGS-1:0][DATA_W-1:0] regs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata     = regs[raddr];
   assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: rtl/accum_core.sv
// Multi-cycle accumulator core: FETCH/EXEC/MEM FSM over a req/ack memory port.
// Define CORE_MAILBOX_HALT_EN to halt on a nonzero write to R31.
module accum_core
   import core_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   input  logic [4:0]        dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DATA_W-1:0] acc_o,
   output logic              halted
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic [7:0]        instr, instr_nxt;

   logic [OP_W-1:0]   op;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] imm_d;
   logic [ADDR_W-1:0] br_off;
   logic [DATA_W-1:0] r_imm;
   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;

   assign op     = instr[7:5];
   assign imm    = instr[4:0];
   assign imm_d  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign br_off = ADDR_W'($signed(imm));

   core_regfile #(.DATA_W(DATA_W)) u_rf (
      .clk       (clk),
      .rst       (rst),
      .we        (rf_we),
      .waddr     (imm),
      .wdata     (rf_wdata),
      .raddr     (imm),
      .rdata     (r_imm),
      .dbg_raddr (dbg_raddr),
      .dbg_rdata (dbg_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_FETCH;
         pc    <= '0;
         acc   <= '0;
         instr <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         acc   <= acc_nxt;
         instr <= instr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      acc_nxt   = acc;
      instr_nxt = instr;
      rf_we     = 1'b0;
      rf_wdata  = acc;
      case (state)
         ST_FETCH: begin
            if (mem_ack) begin
               instr_nxt = mem_rdata[7:0];
               pc_nxt    = pc + ADDR_W'(1);
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt = ST_FETCH;
            case (op)
               OP_LDI:       acc_nxt = imm_d;
               OP_LDA:       acc_nxt = r_imm;
               OP_STA:       rf_we = 1'b1;
               OP_ADD:       acc_nxt = acc + r_imm;
               OP_SUB:       acc_nxt = acc - r_imm;
               OP_LW, OP_SW: state_nxt = ST_MEM;
               OP_BEQZ:      if (acc == '0) pc_nxt = pc + br_off;
               default:      ;
            endcase
         end
         ST_MEM: begin
            if (mem_ack) begin
               state_nxt = ST_FETCH;
               if (op == OP_LW) begin
                  rf_we    = 1'b1;
                  rf_wdata = mem_rdata;
               end
            end
         end
         default: ;
      endcase
`ifdef CORE_MAILBOX_HALT_EN
      if (rf_we && is_mailbox(imm) && rf_wdata != '0) state_nxt = ST_HALT;
`endif
   end

   // Request is gated by rst so it drops the moment reset asserts, not at the next edge.
   assign mem_req   = !rst && (state == ST_FETCH || state == ST_MEM);
   assign mem_we    = (state == ST_MEM) && (op == OP_SW);
   assign mem_addr  = (state == ST_MEM) ? ADDR_W'(acc) : pc;
   assign mem_wdata = r_imm;

   assign pc_o  = pc;
   assign acc_o = acc;

`ifdef CORE_MAILBOX_HALT_EN
   assign halted = (state == ST_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule
